// File: rtl/sha256_pkg.sv
// Shared constants and FSM state type for the SHA-256 message padder.
package sha256_pkg;
    localparam int LEN_W       = 64;
    localparam int CNT_W       = LEN_W - 3;
    localparam int BLOCK_WORDS = 16;
    localparam logic [31:0] PAD_MARKER = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_ACC,
        S_PAD,
        S_EMIT
    } state_t;
endpackage

// File: rtl/sha256_msg_padder_if.sv
// Word-in / block-out bus of the SHA-256 message padder, plus FSM state for debug.
interface sha256_msg_padder_if;
    import sha256_pkg::*;

    // Both channels: a transfer happens on a rising clk edge where valid & ready are high;
    // the source holds its payload stable while valid is high and ready is low.
    logic             padding_en;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic [2:0]       in_bytes;
    logic             blk_valid;
    logic             blk_ready;
    logic [511:0]     blk_data;
    logic             blk_last;
    logic [LEN_W-1:0] msg_bits;
    state_t           dbg_state;

    modport master (
        output padding_en, in_valid, in_data, in_last, in_bytes, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_last, msg_bits, dbg_state
    );

    modport slave (
        input  padding_en, in_valid, in_data, in_last, in_bytes, blk_ready,
        output in_ready, blk_valid, blk_data, blk_last, msg_bits, dbg_state
    );
endinterface

// File: rtl/sha256_pad_word.sv
// Keeps the first 'bytes' bytes of a big-endian word, puts 0x80 right after them, zeroes the rest.
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  bytes,
    output logic [31:0] word
);
    always_comb begin
        word = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < bytes)
                word[31-8*i -: 8] = data[31-8*i -: 8];
            else if (3'(i) == bytes)
                word[31-8*i -: 8] = PAD_MARKER[31:24];
        end
    end
endmodule

// File: rtl/sha256_msg_padder.sv
// FIPS 180-4 message padder: collects 32-bit words into 512-bit blocks, appends marker,
// zero fill and the 64-bit bit length, and flags the final block of each message.
module sha256_msg_padder
    import sha256_pkg::*;
(
    input logic               clk,
    input logic               rst,
    sha256_msg_padder_if.slave bus
);
    state_t           state;
    logic [31:0]      w [BLOCK_WORDS];
    logic [4:0]       idx;
    logic [CNT_W-1:0] byte_cnt;
    logic             marker_pend;
    logic             pad_after;
    logic             final_q;
    logic [31:0]      pad_word;
    logic [4:0]       pad_idx;
    logic [LEN_W-1:0] bit_len;
    logic             acc_fire;

    sha256_pad_word u_pad_word (
        .data  (bus.in_data),
        .bytes (bus.in_bytes),
        .word  (pad_word)
    );

    assign bit_len       = {byte_cnt, 3'b000};
    // First free word once a deferred marker (full last word) has been placed.
    assign pad_idx       = marker_pend ? idx + 5'd1 : idx;
    assign bus.in_ready  = rst && (state == S_ACC) && bus.padding_en;
    assign acc_fire      = bus.in_valid && bus.in_ready;
    assign bus.blk_valid = (state == S_EMIT);
    assign bus.blk_last  = final_q;
    assign bus.msg_bits  = bit_len;
    assign bus.dbg_state = state;

    always_comb begin
        bus.blk_data = '0;
        for (int j = 0; j < BLOCK_WORDS; j++)
            bus.blk_data[511-32*j -: 32] = w[j];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_ACC;
            idx         <= '0;
            byte_cnt    <= '0;
            marker_pend <= 1'b0;
            pad_after   <= 1'b0;
            final_q     <= 1'b0;
            for (int j = 0; j < BLOCK_WORDS; j++) w[j] <= '0;
        end else begin
            case (state)
                S_ACC: begin
                    if (acc_fire) begin
                        byte_cnt     <= byte_cnt + CNT_W'(bus.in_bytes);
                        w[idx[3:0]]  <= pad_word;
                        idx          <= idx + 5'd1;
                        if (!bus.in_last) begin
                            if (idx == 5'd15) begin
                                state   <= S_EMIT;
                                final_q <= 1'b0;
                            end
                        end else if (bus.in_bytes == 3'd4) begin
                            marker_pend <= 1'b1;
                            if (idx == 5'd15) begin
                                state     <= S_EMIT;
                                final_q   <= 1'b0;
                                pad_after <= 1'b1;
                            end else begin
                                state <= S_PAD;
                            end
                        end else begin
                            state <= S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    for (int j = 0; j < BLOCK_WORDS; j++)
                        if (5'(j) >= pad_idx) w[j] <= '0;
                    if (marker_pend) begin
                        w[idx[3:0]] <= PAD_MARKER;
                        marker_pend <= 1'b0;
                    end
                    idx <= pad_idx;
                    // The length needs words 14 and 15; otherwise it spills into one more block.
                    if (pad_idx <= 5'd14) begin
                        w[14]   <= bit_len[63:32];
                        w[15]   <= bit_len[31:0];
                        final_q <= 1'b1;
                    end else begin
                        final_q   <= 1'b0;
                        pad_after <= 1'b1;
                    end
                    state <= S_EMIT;
                end
                S_EMIT: begin
                    if (bus.blk_ready) begin
                        idx <= '0;
                        for (int j = 0; j < BLOCK_WORDS; j++) w[j] <= '0;
                        if (final_q) begin
                            byte_cnt    <= '0;
                            pad_after   <= 1'b0;
                            marker_pend <= 1'b0;
                            final_q     <= 1'b0;
                            state       <= S_ACC;
                        end else if (pad_after) begin
                            state <= S_PAD;
                        end else begin
                            state <= S_ACC;
                        end
                    end
                end
                default: state <= S_ACC;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: directed messages, expected blocks queued per message.
module tb_sha256_msg_padder;
  import sha256_pkg::*;

  localparam int W = 1 + 64 + 512;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sha256_msg_padder_if bus();

  sha256_msg_padder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  logic [7:0] msg_bytes [64];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int num_blocks(input int n);
    return (n + 8) / 64 + 1;
  endfunction

  // Reference padding: bytes, 0x80, zeros, then 8-byte big-endian bit length at the very end.
  function automatic logic [W-1:0] model_block(input int n, input int b);
    logic [511:0] d;
    logic [63:0] bits;
    int p;
    int tail;
    bits = 64'(n) * 64'd8;
    tail = num_blocks(n) * 64 - 8;
    d = '0;
    for (int k = 0; k < 64; k++) begin
      p = b * 64 + k;
      if (p < n) d[511-8*k -: 8] = msg_bytes[p];
      else if (p == n) d[511-8*k -: 8] = 8'h80;
      else if (p >= tail) d[511-8*k -: 8] = bits[63-8*(p-tail) -: 8];
    end
    return {(b == num_blocks(n) - 1), bits, d};
  endfunction

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!bus.in_ready) begin
      failures++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d_pending required=0_pending", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Sends msg_bytes[0..n-1]; junk (0xEE) fills unused lanes of the last word.
  task automatic send_msg(input int n, input bit push, input bit chk_lat, input bit en_gaps);
    int nwords;
    int nb;
    logic [31:0] word;
    nwords = (n == 0) ? 1 : (n + 3) / 4;
    nb = 0;
    if (push)
      for (int b = 0; b < num_blocks(n); b++) exp_q.push_back(model_block(n, b));
    for (int i = 0; i < nwords; i++) begin
      nb = (n - 4 * i > 4) ? 4 : n - 4 * i;
      for (int k = 0; k < 4; k++) begin
        if (k < nb) word[31-8*k -: 8] = msg_bytes[4*i+k];
        else word[31-8*k -: 8] = 8'hEE;
      end
      bus.in_data  = word;
      bus.in_bytes = 3'(nb);
      bus.in_last  = (i == nwords - 1);
      bus.in_valid = 1'b1;
      if (en_gaps && (i % 3 == 1)) begin
        bus.padding_en = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          check("in_ready_gated", W'(bus.in_ready), W'(0));
          @(posedge clk);
          #1;
        end
        bus.padding_en = 1'b1;
      end
      wait_ready();
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (chk_lat) begin
      @(negedge clk);
      if (nwords == 16 && nb == 4) begin
        check("lat_emit_1cyc", W'(bus.blk_valid), W'(1));
      end else begin
        check("lat_pad_cycle", W'(bus.blk_valid), W'(0));
        @(negedge clk);
        check("lat_emit_2cyc", W'(bus.blk_valid), W'(1));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_blk_valid"}, W'(bus.blk_valid), W'(0));
    check({tag, "_blk_last"}, W'(bus.blk_last), W'(0));
    check({tag, "_blk_data"}, W'(bus.blk_data), W'(0));
    check({tag, "_msg_bits"}, W'(bus.msg_bits), W'(0));
    check({tag, "_in_ready"}, W'(bus.in_ready), W'(0));
    check({tag, "_state"}, W'(bus.dbg_state), W'(S_ACC));
  endtask

  task automatic load_abc();
    msg_bytes[0] = 8'h61;
    msg_bytes[1] = 8'h62;
    msg_bytes[2] = 8'h63;
  endtask

  // Monitor: every block handshake is compared against the head of the expected queue.
  always @(negedge clk) begin
    if (rst && bus.blk_valid && bus.blk_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_block actual=%0h required=none", bus.blk_data);
      end else begin
        check("block", {bus.blk_last, bus.msg_bits, bus.blk_data}, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst && bus.in_valid)
      assert (bus.in_bytes <= 3'd4 && (bus.in_last || bus.in_bytes == 3'd4))
        else $error("illegal in_bytes=%0d in_last=%0b", bus.in_bytes, bus.in_last);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] exp_blk;
    int t;
    bus.padding_en = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.in_bytes   = '0;
    bus.blk_ready  = 1'b1;
    for (int i = 0; i < 64; i++) msg_bytes[i] = 8'(i * 37 + 5);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // "abc"
    load_abc();
    exp_q.push_back({1'b1, 64'd24, 32'h6162_6380, 448'd0, 32'h0000_0018});
    send_msg(3, 1'b0, 1'b1, 1'b0);
    drain();
    check("msg_bits_cleared", W'(bus.msg_bits), W'(0));

    // Empty message
    exp_q.push_back({1'b1, 64'd0, 32'h8000_0000, 480'd0});
    send_msg(0, 1'b0, 1'b1, 1'b0);
    drain();

    // 55 bytes: single block
    for (int i = 0; i < 64; i++) msg_bytes[i] = 8'(i * 37 + 5);
    send_msg(55, 1'b1, 1'b1, 1'b0);
    drain();

    // 56 bytes: length spills into a second block
    exp_q.push_back(model_block(56, 0));
    exp_q.push_back({1'b1, 64'd448, 480'd0, 32'h0000_01C0});
    send_msg(56, 1'b0, 1'b1, 1'b0);
    drain();

    // 64 bytes: marker and length in a second block
    exp_q.push_back(model_block(64, 0));
    exp_q.push_back({1'b1, 64'd512, 32'h8000_0000, 448'd0, 32'h0000_0200});
    send_msg(64, 1'b0, 1'b1, 1'b0);
    drain();

    // Backpressure on the block side, with padding_en gaps on input
    bus.blk_ready = 1'b0;
    send_msg(8, 1'b1, 1'b0, 1'b1);
    exp_blk = model_block(8, 0);
    t = 0;
    @(negedge clk);
    while (!bus.blk_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (10) begin
      check("bp_blk_valid", W'(bus.blk_valid), W'(1));
      check("bp_blk_hold", {bus.blk_last, bus.msg_bits, bus.blk_data}, exp_blk);
      check("bp_in_ready", W'(bus.in_ready), W'(0));
      @(negedge clk);
    end
    bus.blk_ready = 1'b1;
    drain();

    // Longer message with padding_en toggling
    send_msg(41, 1'b1, 1'b1, 1'b1);
    drain();

    // Reset in the middle of a message, then a fresh "abc"
    for (int i = 0; i < 7; i++) begin
      bus.in_data  = 32'hA5A5_0000 + 32'(i);
      bus.in_bytes = 3'd4;
      bus.in_last  = 1'b0;
      bus.in_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    load_abc();
    exp_q.push_back({1'b1, 64'd24, 32'h6162_6380, 448'd0, 32'h0000_0018});
    send_msg(3, 1'b0, 1'b1, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
